axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
- AXI4-Lite initiator: converts a single-outstanding, memory-like request port (req/gnt/we/addr/wdata) into AXI4-Lite transactions on an AXI_BUS master port.
- Counterpart of the AXI-Lite slave interface. Lets small in-house agents (debug, boot loader, timer test drivers) reach AXI-Lite peripherals.
- One transaction in flight at a time. Each transaction returns one response pulse.

Parameters:
- AXI_ADDR_WIDTH, 64: address width of the bus and of the request port.
- AXI_DATA_WIDTH, 64: data width. Strobe width is AXI_DATA_WIDTH/8.
- AXI_ID_WIDTH, 10: width of the AXI ID fields.
- AXI_ID, 0: constant ID driven on aw_id and ar_id.
- TIMEOUT_CYCLES, 1024: response timeout in cycles. Used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- master  AXI_BUS.Master  -  AXI4-Lite bus towards the slave.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted in this cycle.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  AXI_ADDR_WIDTH  byte address.
- wdata_i  in  AXI_DATA_WIDTH  write data.
- wstrb_i  in  AXI_DATA_WIDTH/8  write byte enables.
- rvalid_o  out  1  one-cycle response pulse, for both reads and writes.
- rdata_o  out  AXI_DATA_WIDTH  read data. Valid with rvalid_o; 0 for writes.
- err_o  out  1  error flag, valid with rvalid_o.

Behaviour:
- Reset values: all valids and readys low; gnt_o, rvalid_o and err_o are 0; rdata_o is 0; the FSM is in IDLE.
- A reset mid-transaction aborts it immediately. No response pulse is produced.
- Static AXI fields:
  - len = 0, size = $clog2(AXI_DATA_WIDTH/8), burst = INCR.
  - lock, cache, prot, qos, region, user = 0.
  - w_last = 1.
- gnt_o = req_i only while in IDLE (combinational). On grant, addr/wdata/wstrb/we are latched.
- States:
  - IDLE: on grant with we_i=1, go to WR. With we_i=0, go to RD_AR.
  - WR: aw_valid and w_valid are asserted from the cycle after grant.
    - Each channel is dropped independently once its handshake completes; two flags track this.
    - Both may complete in the same cycle.
    - When both have completed, go to WR_B.
    - A valid is never withdrawn before its ready.
  - WR_B: b_ready=1. On b_valid, go to IDLE and pulse rvalid_o with err_o = b_resp[1].
  - RD_AR: ar_valid=1. On ar_ready, go to RD_R.
  - RD_R: r_ready=1. On r_valid, go to IDLE, pulse rvalid_o, rdata_o = r_data, err_o = r_resp[1].
- b_ready and r_ready are low outside WR_B and RD_R.
- Latency with a zero-wait slave:
  - Write: grant at T, AW/W handshake at T+1, B at T+2 or later, rvalid_o in the cycle after B.
  - Read: AR handshake at T+1, R at T+2 or later, rvalid_o in the cycle after R.
- rvalid_o, rdata_o and err_o are registered.
- Response IDs (b_id, r_id) are ignored. Only one transaction is ever outstanding.
- A new grant is possible in the same cycle rvalid_o is high, because the FSM is back in IDLE.
- r_last is ignored.

Optional Feature:
- Macro: AXI_LITE_MASTER_TIMEOUT_EN.
- Enabled:
  - A counter starts at grant and increments every cycle while not in IDLE.
  - If it reaches TIMEOUT_CYCLES-1 before the response handshake, pulse rvalid_o with err_o=1 and rdata_o=0, and set an orphan flag.
  - The FSM continues the bus transaction normally, because AXI valids may not be dropped.
  - The final response is consumed silently: no second rvalid_o pulse.
  - gnt_o stays low until the FSM reaches IDLE. The orphan flag clears there.
  - A response arriving in the same cycle as expiry wins: normal response, no timeout.
- Disabled: no counter or orphan logic; the block waits indefinitely.

Decomposition:
- Shared package axi_lite_pkg holds:
  - the state enum type;
  - constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_INCR=2'b01;
  - a function computing size from the data width.
- No sub-module: a single FSM plus registers. The timeout counter is inline under the macro.

Test Plan:
- Single write: addr=0x1000, wdata=0xDEADBEEF_CAFEF00D, wstrb=0xFF, slave ready at once, b_resp=OKAY → AW and W in the same cycle with w_last=1; rvalid_o pulses once with err_o=0; gnt_o then reasserts.
- AW/W skew: slave holds w_ready low 5 cycles after aw_ready → aw_valid drops after its handshake, w_valid stays high and stable, exactly one B is accepted, then one rvalid_o.
- Read: addr=0x2008, slave returns r_data=0x0123456789ABCDEF with r_resp=SLVERR after 3 wait cycles → rdata_o=0x0123456789ABCDEF, err_o=1, one pulse.
- Back-to-back: req_i held high across 4 alternating reads and writes → each grant only in IDLE, no overlapping valids, responses in order, len=0 and size=3 on every address beat.
- Reset mid-read: rst_ni low while in RD_R → ar_valid, r_ready and rvalid_o are 0 immediately; FSM in IDLE after release.
- With AXI_LITE_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16: slave withholds b_valid for 40 cycles → rvalid_o with err_o=1 in cycle 16 after grant; the late B is accepted with no second pulse; gnt_o stays low until then.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite initiator: FSM state encoding,
// AXI response/burst codes and the beat-size helper.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WR_B  = 3'd2,
        RD_AR = 3'd3,
        RD_R  = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_bus_intf.sv
// AXI4 bus bundle used by the initiator; only the AXI4-Lite subset is exercised,
// burst fields are carried so the bus plugs into full-AXI fabric unchanged.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding req/gnt port to AXI4-Lite initiator; optional response timeout via AXI_LITE_MASTER_TIMEOUT_EN.
// Zero-wait slave: write AW/W at T+1, read AR at T+1, rvalid_o one cycle after B/R; gnt_o held low while busy.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_ID         = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    AXI_BUS.Master                        master,
    input  logic                          req_i,
    output logic                          gnt_o,
    input  logic                          we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_i,
    output logic                          rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]     rdata_o,
    output logic                          err_o
);

    state_e                        state;
    logic                          aw_done;
    logic                          w_done;
    logic [AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0]   wstrb_q;
    logic                          aw_hs;
    logic                          w_hs;
    logic                          rsp_hs;
    logic                          orphan;
    logic                          expire;

    assign gnt_o  = req_i && (state == IDLE);
    assign aw_hs  = master.aw_valid && master.aw_ready;
    assign w_hs   = master.w_valid && master.w_ready;
    assign rsp_hs = ((state == WR_B) && master.b_valid) || ((state == RD_R) && master.r_valid);

    assign master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.aw_addr   = addr_q;
    assign master.aw_len    = '0;
    assign master.aw_size   = axi_size(AXI_DATA_WIDTH);
    assign master.aw_burst  = BURST_INCR;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = '0;
    assign master.aw_prot   = '0;
    assign master.aw_qos    = '0;
    assign master.aw_region = '0;
    assign master.aw_user   = '0;
    assign master.aw_valid  = (state == WR) && !aw_done;

    assign master.w_data    = wdata_q;
    assign master.w_strb    = wstrb_q;
    assign master.w_last    = 1'b1;
    assign master.w_user    = '0;
    assign master.w_valid   = (state == WR) && !w_done;

    assign master.b_ready   = (state == WR_B);

    assign master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.ar_addr   = addr_q;
    assign master.ar_len    = '0;
    assign master.ar_size   = axi_size(AXI_DATA_WIDTH);
    assign master.ar_burst  = BURST_INCR;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = '0;
    assign master.ar_prot   = '0;
    assign master.ar_qos    = '0;
    assign master.ar_region = '0;
    assign master.ar_user   = '0;
    assign master.ar_valid  = (state == RD_AR);

    assign master.r_ready   = (state == RD_R);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] tmo_cnt;

    // A response landing in the expiry cycle takes priority over the timeout.
    assign expire = (state != IDLE) && !orphan && !rsp_hs &&
                    (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
            orphan  <= 1'b0;
        end else if (state == IDLE) begin
            orphan  <= 1'b0;
            tmo_cnt <= gnt_o ? CNT_W'(1) : '0;
        end else begin
            if (!orphan) tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (expire)  orphan  <= 1'b1;
        end
    end
`else
    assign orphan = 1'b0;
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            if (expire) begin
                rvalid_o <= 1'b1;
                rdata_o  <= '0;
                err_o    <= 1'b1;
            end
            case (state)
                IDLE: if (req_i) begin
                    addr_q  <= addr_i;
                    wdata_q <= wdata_i;
                    wstrb_q <= wstrb_i;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    state   <= we_i ? WR : RD_AR;
                end
                WR: begin
                    aw_done <= aw_done | aw_hs;
                    w_done  <= w_done | w_hs;
                    if ((aw_done | aw_hs) && (w_done | w_hs)) state <= WR_B;
                end
                WR_B: if (master.b_valid) begin
                    state <= IDLE;
                    // After a timeout the late response is drained without a second pulse.
                    if (!orphan) begin
                        rvalid_o <= 1'b1;
                        rdata_o  <= '0;
                        err_o    <= master.b_resp[1];
                    end
                end
                RD_AR: if (master.ar_ready) state <= RD_R;
                RD_R: if (master.r_valid) begin
                    state <= IDLE;
                    if (!orphan) begin
                        rvalid_o <= 1'b1;
                        rdata_o  <= master.r_data;
                        err_o    <= master.r_resp[1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
`timescale 1ns/1ps
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 10;
    localparam int TO = 16;

    logic          clk_i   = 1'b1;
    logic          rst_ni  = 1'b0;
    logic          req_i   = 1'b0;
    logic          we_i    = 1'b0;
    logic [AW-1:0] addr_i  = '0;
    logic [DW-1:0] wdata_i = '0;
    logic [7:0]    wstrb_i = '0;
    logic          gnt_o;
    logic          rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          err_o;

    AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(1)) bus ();

    axi_lite_master #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
        .AXI_ID(0), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .master(bus),
        .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one transaction owned at a time, response expected one
    // cycle after the slave's response handshake, or at grant+TO on timeout.
    bit            busy, orphan, exp_rv, exp_err, gnt_seen;
    logic [DW-1:0] exp_rdata;
    int            cyc, g_cyc;
    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic [7:0]    cur_wstrb;
    // slave configuration: next (set by stimulus) and current (latched at grant)
    int            nx_aw, nx_w, nx_b, nx_ar, nx_r, c_aw, c_w, c_b, c_ar, c_r;
    logic [1:0]    nx_resp, c_resp;
    logic [DW-1:0] nx_rdata, c_rdata;
    int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit            got_aw, got_w, got_ar, b_hs, r_hs, rsp;
    bit            p_aw, p_w, p_ar;
    logic [AW-1:0] p_aw_addr, p_ar_addr;
    logic [DW-1:0] p_w_data;
    int            rv_cnt, nb, last_rv_cyc, aw_hs_cyc, w_hs_cyc;
    logic [DW-1:0] last_rv_dat;
    logic          last_rv_err;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
            bus.b_valid = 1'b0; bus.b_resp = '0; bus.b_id = '0; bus.b_user = '0;
            bus.r_valid = 1'b0; bus.r_data = '0; bus.r_resp = '0; bus.r_id = '0;
            bus.r_last = 1'b1; bus.r_user = '0;
            busy = 0; orphan = 0; exp_rv = 0; got_aw = 0; got_w = 0; got_ar = 0;
            b_hs = 0; r_hs = 0; p_aw = 0; p_w = 0; p_ar = 0;
        end else begin
            cyc++;
            chk("rvalid", rvalid_o, exp_rv);
            if (rvalid_o) begin
                rv_cnt++; last_rv_cyc = cyc; last_rv_dat = rdata_o; last_rv_err = err_o;
            end
            if (exp_rv) begin
                chk("rdata", rdata_o, exp_rdata);
                chk("err", err_o, exp_err);
            end
            exp_rv = 0;
            chk("gnt", gnt_o, req_i && !busy);
            if (p_aw) begin chk("aw_hold", bus.aw_valid, 1); chk("aw_addr_hold", bus.aw_addr, p_aw_addr); end
            if (p_w)  begin chk("w_hold", bus.w_valid, 1);   chk("w_data_hold", bus.w_data, p_w_data); end
            if (p_ar) begin chk("ar_hold", bus.ar_valid, 1); chk("ar_addr_hold", bus.ar_addr, p_ar_addr); end
            if (bus.ar_valid || bus.r_ready)
                chk("rd_excl", {bus.aw_valid, bus.w_valid, bus.b_ready}, 0);
            if (req_i && gnt_o) begin
                busy = 1; orphan = 0; g_cyc = cyc; gnt_seen = 1;
                cur_we = we_i; cur_addr = addr_i; cur_wdata = wdata_i; cur_wstrb = wstrb_i;
                c_aw = nx_aw; c_w = nx_w; c_b = nx_b; c_ar = nx_ar; c_r = nx_r;
                c_resp = nx_resp; c_rdata = nx_rdata;
                got_aw = 0; got_w = 0; got_ar = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end
            // slave drive
            if (b_hs) bus.b_valid = 1'b0;
            if (r_hs) bus.r_valid = 1'b0;
            b_hs = 0; r_hs = 0;
            bus.aw_ready = 1'b0;
            if (bus.aw_valid) begin if (aw_cnt >= c_aw) bus.aw_ready = 1'b1; else aw_cnt++; end
            bus.w_ready = 1'b0;
            if (bus.w_valid) begin if (w_cnt >= c_w) bus.w_ready = 1'b1; else w_cnt++; end
            bus.ar_ready = 1'b0;
            if (bus.ar_valid) begin if (ar_cnt >= c_ar) bus.ar_ready = 1'b1; else ar_cnt++; end
            if (got_aw && got_w && !bus.b_valid) begin
                if (b_cnt >= c_b) begin bus.b_valid = 1'b1; bus.b_resp = c_resp; end
                else b_cnt++;
            end
            if (got_ar && !bus.r_valid) begin
                if (r_cnt >= c_r) begin bus.r_valid = 1'b1; bus.r_resp = c_resp; bus.r_data = c_rdata; end
                else r_cnt++;
            end
            // handshakes taking place at the coming posedge
            p_aw = bus.aw_valid && !bus.aw_ready; p_aw_addr = bus.aw_addr;
            p_w  = bus.w_valid && !bus.w_ready;   p_w_data  = bus.w_data;
            p_ar = bus.ar_valid && !bus.ar_ready; p_ar_addr = bus.ar_addr;
            if (bus.aw_valid && bus.aw_ready) begin
                chk("aw_dir", cur_we, 1); chk("aw_addr", bus.aw_addr, cur_addr);
                chk("aw_len", bus.aw_len, 0); chk("aw_size", bus.aw_size, 3);
                chk("aw_burst", bus.aw_burst, 1); chk("aw_id", bus.aw_id, 0);
                chk("aw_misc", {bus.aw_lock, bus.aw_cache, bus.aw_prot, bus.aw_qos, bus.aw_region}, 0);
                got_aw = 1; aw_hs_cyc = cyc;
            end
            if (bus.w_valid && bus.w_ready) begin
                chk("w_data", bus.w_data, cur_wdata); chk("w_strb", bus.w_strb, cur_wstrb);
                chk("w_last", bus.w_last, 1);
                got_w = 1; w_hs_cyc = cyc;
            end
            if (bus.ar_valid && bus.ar_ready) begin
                chk("ar_dir", cur_we, 0); chk("ar_addr", bus.ar_addr, cur_addr);
                chk("ar_len", bus.ar_len, 0); chk("ar_size", bus.ar_size, 3);
                chk("ar_burst", bus.ar_burst, 1);
                got_ar = 1;
            end
            rsp = 0;
            if (bus.b_valid && bus.b_ready) begin
                b_hs = 1; got_aw = 0; got_w = 0; nb++; rsp = 1; busy = 0;
                if (!orphan) begin exp_rv = 1; exp_err = c_resp[1]; exp_rdata = '0; end
            end
            if (bus.r_valid && bus.r_ready) begin
                r_hs = 1; got_ar = 0; rsp = 1; busy = 0;
                if (!orphan) begin exp_rv = 1; exp_err = c_resp[1]; exp_rdata = c_rdata; end
            end
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
            if (busy && !orphan && !rsp && (cyc == g_cyc + TO - 1)) begin
                orphan = 1; exp_rv = 1; exp_err = 1; exp_rdata = '0;
            end
`endif
        end
    end

    task automatic set_cfg(input int aw, input int w, input int b, input int ar, input int r,
                           input logic [1:0] resp, input logic [63:0] rd);
        nx_aw = aw; nx_w = w; nx_b = b; nx_ar = ar; nx_r = r; nx_resp = resp; nx_rdata = rd;
    endtask

    task automatic issue(input logic we, input logic [63:0] a, input logic [63:0] d,
                         input logic [7:0] s, input bit hold);
        int n;
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d; wstrb_i = s;
        n = 0;
        while (!gnt_seen && n < 300) begin @(posedge clk_i); #1; n++; end
        chk("gnt_wait", gnt_seen, 1);
        gnt_seen = 0;
        if (!hold) req_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin @(posedge clk_i); #1; n++; end
        chk("idle_wait", busy, 0);
        repeat (2) begin @(posedge clk_i); #1; end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0, nb0;
        set_cfg(0, 0, 0, 0, 0, RESP_OKAY, '0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_gnt", gnt_o, 0);      chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rdata", rdata_o, 0);  chk("rst_err", err_o, 0);
        chk("rst_valids", {bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready}, 0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // single write, zero-wait slave
        rv0 = rv_cnt;
        set_cfg(0, 0, 0, 0, 0, RESP_OKAY, '0);
        issue(1'b1, 64'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0);
        wait_idle();
        chk("wr_aw_w_same", aw_hs_cyc, w_hs_cyc);
        chk("wr_lat", last_rv_cyc - g_cyc, 3);
        chk("wr_pulses", rv_cnt - rv0, 1);
        chk("wr_err", last_rv_err, 0);

        // AW/W skew
        rv0 = rv_cnt; nb0 = nb;
        set_cfg(0, 5, 0, 0, 0, RESP_OKAY, '0);
        issue(1'b1, 64'h3000, {$urandom, $urandom}, 8'h0F, 0);
        wait_idle();
        chk("skew_gap", w_hs_cyc - aw_hs_cyc, 5);
        chk("skew_b", nb - nb0, 1);
        chk("skew_pulses", rv_cnt - rv0, 1);

        // read with wait states and SLVERR
        rv0 = rv_cnt;
        set_cfg(0, 0, 0, 0, 3, RESP_SLVERR, 64'h0123456789ABCDEF);
        issue(1'b0, 64'h2008, '0, 8'h00, 0);
        wait_idle();
        chk("rd_data", last_rv_dat, 64'h0123456789ABCDEF);
        chk("rd_err", last_rv_err, 1);
        chk("rd_pulses", rv_cnt - rv0, 1);

        // back-to-back alternating with req_i held high
        rv0 = rv_cnt;
        for (int i = 0; i < 4; i++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 1) ? RESP_SLVERR : RESP_OKAY, {$urandom, $urandom});
            issue(i[0] ? 1'b0 : 1'b1, {32'h0, $urandom} & ~64'h7, {$urandom, $urandom},
                  8'($urandom), i != 3);
        end
        wait_idle();
        chk("b2b_pulses", rv_cnt - rv0, 4);

        // randomized traffic
        rv0 = rv_cnt;
        for (int i = 0; i < 40; i++) begin
            set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                    $urandom_range(0, 6), $urandom_range(0, 6),
                    $urandom_range(0, 1) ? RESP_SLVERR : RESP_OKAY, {$urandom, $urandom});
            issue(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                  (i != 39) && ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();
        chk("rand_pulses", rv_cnt - rv0, 40);

        // reset while waiting in the R phase
        begin
            int n;
            set_cfg(0, 0, 0, 0, 50, RESP_OKAY, '0);
            issue(1'b0, 64'h4000, '0, 8'h00, 0);
            n = 0;
            while (!bus.r_ready && n < 20) begin @(posedge clk_i); #1; n++; end
            chk("rr_reached", bus.r_ready, 1);
            rst_ni = 1'b0;
            #1;
            chk("mrst_ar_valid", bus.ar_valid, 0);
            chk("mrst_r_ready", bus.r_ready, 0);
            chk("mrst_rvalid", rvalid_o, 0);
            repeat (2) @(posedge clk_i);
            #1;
            rst_ni = 1'b1;
            @(posedge clk_i); #1;
            rv0 = rv_cnt;
            req_i = 1'b1; we_i = 1'b0;
            #1;
            chk("mrst_idle_gnt", gnt_o, 1);
            set_cfg(0, 0, 0, 0, 0, RESP_OKAY, 64'h55AA);
            issue(1'b0, 64'h4008, '0, 8'h00, 0);
            wait_idle();
            chk("mrst_pulses", rv_cnt - rv0, 1);
            chk("mrst_rdata", last_rv_dat, 64'h55AA);
        end

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // slave withholds B well past the timeout
        rv0 = rv_cnt; nb0 = nb;
        set_cfg(0, 0, 40, 0, 0, RESP_OKAY, '0);
        issue(1'b1, 64'h5000, {$urandom, $urandom}, 8'hFF, 0);
        wait_idle();
        chk("to_pulses", rv_cnt - rv0, 1);
        chk("to_lat", last_rv_cyc - g_cyc, TO);
        chk("to_err", last_rv_err, 1);
        chk("to_late_b", nb - nb0, 1);
        // B handshake in the expiry cycle wins
        rv0 = rv_cnt;
        set_cfg(0, 0, 13, 0, 0, RESP_OKAY, '0);
        issue(1'b1, 64'h5008, {$urandom, $urandom}, 8'hFF, 0);
        wait_idle();
        chk("to_edge_pulses", rv_cnt - rv0, 1);
        chk("to_edge_err", last_rv_err, 0);
        // B one cycle after expiry is orphaned
        rv0 = rv_cnt;
        set_cfg(0, 0, 14, 0, 0, RESP_OKAY, '0);
        issue(1'b1, 64'h5010, {$urandom, $urandom}, 8'hFF, 0);
        wait_idle();
        chk("to_late_pulses", rv_cnt - rv0, 1);
        chk("to_late_err", last_rv_err, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
